// File: rtl/psg_bus_master.sv
// Host-side bus initiator for an AY-3-8912 compatible PSG: queues register requests
// and replays each one as BDIR/BC1 phases (address latch, data, inactive gap) on ce.
module psg_bus_master #(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] ADDR_HI    = 4'b0000,
  parameter bit         ADDR_CACHE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] d,
  input  logic [7:0] q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} state_t;

  logic [12:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  logic          head_wr;
  logic [3:0]    head_addr;
  logic [7:0]    head_data;
  logic          hit;

  state_t        state;
  state_t        state_nxt;
  logic          cur_wr;
  logic [7:0]    cur_data;
  logic          cache_vld;
  logic [3:0]    cache_addr;
  logic          cache_load;
  logic          rsp_fire;
  logic          bdir_nxt;
  logic          bc1_nxt;
  logic [7:0]    d_nxt;

  assign req_ready = (count != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign busy      = (count != '0) || (state != IDLE);

  assign head_wr   = fifo_mem[rd_ptr][12];
  assign head_addr = fifo_mem[rd_ptr][11:8];
  assign head_data = fifo_mem[rd_ptr][7:0];
  assign hit       = ADDR_CACHE && cache_vld && (cache_addr == head_addr);

  // Request queue: push is clock-rate, pop is ce-rate
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {req_wr, req_addr, req_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer: bus values are computed for the phase being entered
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    cache_load = 1'b0;
    rsp_fire   = 1'b0;
    bdir_nxt   = bdir;
    bc1_nxt    = bc1;
    d_nxt      = d;
    if (ce) begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            pop = 1'b1;
            if (hit) begin
              state_nxt = DATA;
              bdir_nxt  = head_wr;
              bc1_nxt   = !head_wr;
              d_nxt     = head_wr ? head_data : 8'h00;
            end else begin
              state_nxt  = ADDR;
              cache_load = 1'b1;
              bdir_nxt   = 1'b1;
              bc1_nxt    = 1'b1;
              d_nxt      = {ADDR_HI, head_addr};
            end
          end
        end
        ADDR: begin
          state_nxt = DATA;
          bdir_nxt  = cur_wr;
          bc1_nxt   = !cur_wr;
          d_nxt     = cur_wr ? cur_data : 8'h00;
        end
        DATA: begin
          state_nxt = GAP;
          rsp_fire  = !cur_wr;
          bdir_nxt  = 1'b0;
          bc1_nxt   = 1'b0;
          d_nxt     = 8'h00;
        end
        GAP: begin
          state_nxt = IDLE;
          bdir_nxt  = 1'b0;
          bc1_nxt   = 1'b0;
          d_nxt     = 8'h00;
        end
        default: begin
          state_nxt = IDLE;
          bdir_nxt  = 1'b0;
          bc1_nxt   = 1'b0;
          d_nxt     = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pop) begin
      cur_wr   <= head_wr;
      cur_data <= head_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bdir       <= 1'b0;
      bc1        <= 1'b0;
      d          <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      cache_vld  <= 1'b0;
      cache_addr <= 4'h0;
    end else begin
      state     <= state_nxt;
      bdir      <= bdir_nxt;
      bc1       <= bc1_nxt;
      d         <= d_nxt;
      rsp_valid <= rsp_fire;
      if (rsp_fire) rsp_data <= q;
      if (cache_load) begin
        cache_vld  <= 1'b1;
        cache_addr <= head_addr;
      end
    end
  end

endmodule
